// File: rtl/ram3_pkg.sv
// ram3_pkg: shared sizing, stored word width and FSM state type for ram3.
// Optional feature macro: RAM3_PARITY_EN (adds an even-parity bit per word).
package ram3_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

`ifdef RAM3_PARITY_EN
  localparam int unsigned WORD_W = DATA_W + 1;
`else
  localparam int unsigned WORD_W = DATA_W;
`endif

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

endpackage

// File: rtl/ram3_if.sv
// ram3_if: address/data/strobe bus between a simple master and ram3.
interface ram3_if;
  import ram3_pkg::*;

  logic [DATA_W-1:0] data_out;
  logic [DATA_W-1:0] data_in;
  logic [ADDR_W-1:0] addr;
  logic              wr;
  logic              cs;
  logic              busy;
  logic              parity_err;

  modport master (
    output data_in, addr, wr, cs,
    input  data_out, busy, parity_err
  );

  modport slave (
    input  data_in, addr, wr, cs,
    output data_out, busy, parity_err
  );
endinterface

// File: rtl/ram3_mem.sv
// ram3_mem: storage array with one synchronous write port and one
// registered read port sharing a single address.
module ram3_mem #(
  parameter int unsigned WORD_W = 8,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [0:(1<<ADDR_W)-1];

  // Array write; contents are never reset, the clear sweep zeroes them.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  // Read register; holds between reads and is zeroed by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/ram3.sv
// ram3: 1024 x 8 single-port synchronous RAM with chip select, write enable
// and a post-reset clear sweep.
// Optional feature macro: RAM3_PARITY_EN (stored even parity, parity_err).
module ram3
  import ram3_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  ram3_if.slave  bus
);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] clr_cnt, clr_cnt_nxt;

  logic              mem_we;
  logic              mem_re;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;
  logic [WORD_W-1:0] mem_rdata;
  logic [WORD_W-1:0] host_wdata;

`ifdef RAM3_PARITY_EN
  assign host_wdata = {^bus.data_in, bus.data_in};
`else
  assign host_wdata = bus.data_in;
`endif

  // State and sweep counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  // Next state and memory port muxing: sweep owns the port while clearing.
  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    mem_we      = 1'b0;
    mem_re      = 1'b0;
    mem_addr    = bus.addr;
    mem_wdata   = host_wdata;
    unique case (state)
      CLEAR: begin
        // All-zero word already carries correct even parity.
        mem_we      = 1'b1;
        mem_addr    = clr_cnt;
        mem_wdata   = '0;
        clr_cnt_nxt = clr_cnt + 1'b1;
        if (clr_cnt == '1) state_nxt = READY;
      end
      READY: begin
        mem_we = bus.cs & bus.wr;
        mem_re = bus.cs & ~bus.wr;
      end
      default: state_nxt = CLEAR;
    endcase
  end

  ram3_mem #(
    .WORD_W (WORD_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (mem_we),
    .re    (mem_re),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

  assign bus.busy     = (state == CLEAR);
  assign bus.data_out = mem_rdata[DATA_W-1:0];

`ifdef RAM3_PARITY_EN
  // Read register holds data and stored parity together, so the check
  // below is effectively registered alongside data_out.
  assign bus.parity_err = ^mem_rdata;
`else
  assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_ram3.sv
// tb_ram3: self-checking bench for ram3 (table vectors, hand sequences and
// random traffic against a word-array reference model).
module tb_ram3;
  import ram3_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram3_if bus();

  ram3 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [7:0] ref_mem [0:1023];
  logic [7:0] ref_dout;

  typedef struct {
    logic       cs;
    logic       wr;
    logic [9:0] addr;
    logic [7:0] din;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // One access on the next rising edge; outputs sampled 1 time unit later.
  task automatic access(input logic c, input logic w, input logic [9:0] a, input logic [7:0] d);
    bus.cs = c; bus.wr = w; bus.addr = a; bus.data_in = d;
    @(posedge clk); #1;
    if (c && w)  ref_mem[a] = d;
    if (c && !w) ref_dout = ref_mem[a];
    bus.cs = 1'b0; bus.wr = 1'b0;
  endtask

  // Counts rising edges with busy high, bounded.
  task automatic count_busy(output int unsigned n);
    n = 0;
    while (bus.busy === 1'b1 && n < 1100) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
    ref_dout = 8'h00;
  endtask

  initial begin
    int unsigned n;
    bus.cs = 1'b0; bus.wr = 1'b0; bus.addr = '0; bus.data_in = '0;

    vecs[0]  = '{1'b1, 1'b0, 10'd300,  8'h00, 8'd88};
    vecs[1]  = '{1'b1, 1'b0, 10'd1023, 8'h00, 8'd254};
    vecs[2]  = '{1'b1, 1'b1, 10'd7,    8'hA5, 8'd254};
    vecs[3]  = '{1'b1, 1'b0, 10'd7,    8'h00, 8'hA5};
    vecs[4]  = '{1'b1, 1'b0, 10'd5,    8'h00, 8'd10};
    vecs[5]  = '{1'b0, 1'b1, 10'd5,    8'hFF, 8'd10};
    vecs[6]  = '{1'b0, 1'b1, 10'd5,    8'hFF, 8'd10};
    vecs[7]  = '{1'b0, 1'b0, 10'd9,    8'hFF, 8'd10};
    vecs[8]  = '{1'b1, 1'b0, 10'd5,    8'h00, 8'd10};
    vecs[9]  = '{1'b1, 1'b1, 10'd5,    8'h33, 8'd10};
    vecs[10] = '{1'b1, 1'b0, 10'd5,    8'h00, 8'h33};
    vecs[11] = '{1'b1, 1'b0, 10'd0,    8'h00, 8'd0};

    // Reset and clear sweep
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", bus.busy, 1'b1);
    chk("rst_dout", bus.data_out, 8'h00);
    chk("rst_perr", bus.parity_err, 1'b0);
    rst_n = 1'b1;
    count_busy(n);
    chk("sweep_len", n, 1024);

    access(1'b1, 1'b0, 10'd0, 8'h00);    chk("clr_rd0",    bus.data_out, 8'h00);
    access(1'b1, 1'b0, 10'd511, 8'h00);  chk("clr_rd511",  bus.data_out, 8'h00);
    access(1'b1, 1'b0, 10'd1023, 8'h00); chk("clr_rd1023", bus.data_out, 8'h00);

    // Fill and readback
    for (int k = 0; k < 1024; k++) access(1'b1, 1'b1, 10'(k), 8'((2 * k) % 256));
    for (int k = 0; k < 1024; k++) begin
      access(1'b1, 1'b0, 10'(k), 8'h00);
      chk("fill_rd", bus.data_out, ref_dout);
    end

    // Table vectors: latency, no write-through, deselect hold
    for (int i = 0; i < 12; i++) begin
      access(vecs[i].cs, vecs[i].wr, vecs[i].addr, vecs[i].din);
      chk($sformatf("vec%0d", i), bus.data_out, vecs[i].exp);
      chk("vec_model", bus.data_out, ref_dout);
    end

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      access(1'($urandom), 1'($urandom), 10'($urandom), 8'($urandom));
      chk("rand_dout", bus.data_out, ref_dout);
      chk("rand_perr", bus.parity_err, 1'b0);
    end

`ifdef RAM3_PARITY_EN
    access(1'b1, 1'b1, 10'd20, 8'h3C);
    access(1'b1, 1'b0, 10'd20, 8'h00);
    chk("par_ok_dout", bus.data_out, 8'h3C);
    chk("par_ok_err", bus.parity_err, 1'b0);
    dut.u_mem.mem[20] = dut.u_mem.mem[20] ^ 9'h001;
    access(1'b1, 1'b0, 10'd20, 8'h00);
    chk("par_bad_dout", bus.data_out, 8'h3D);
    chk("par_bad_err", bus.parity_err, 1'b1);
    access(1'b1, 1'b0, 10'd21, 8'h00);
    chk("par_next_err", bus.parity_err, 1'b0);
`endif

    // Reset mid-sweep
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    model_reset();
    repeat (500) begin @(posedge clk); #1; end
    chk("mid_busy_pre", bus.busy, 1'b1);
    rst_n = 1'b0;
    #2;
    chk("mid_busy_rst", bus.busy, 1'b1);
    chk("mid_dout_rst", bus.data_out, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    chk("mid_busy_hold", bus.busy, 1'b1);
    rst_n = 1'b1;
    count_busy(n);
    chk("mid_sweep_len", n, 1024);
    for (int k = 0; k < 1024; k++) begin
      access(1'b1, 1'b0, 10'(k), 8'h00);
      chk("mid_clr_rd", bus.data_out, 8'h00);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ram3.md
# ram3

Single-port synchronous 1024 x 8 RAM with chip select and write enable. After every reset it runs a built-in clear sweep that zeroes all locations, then accepts one access per clock. It is a general-purpose on-chip storage block for data buffers and lookup tables, sitting directly behind a simple address/data/strobe master.

## Interface
Parameters:
- DATA_W, 8, word width in bits.
- ADDR_W, 10, address width in bits.
- DEPTH, 2**ADDR_W (1024), number of words. Derived; not overridable independently.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- data_out  out  DATA_W  registered read data.
- data_in  in  DATA_W  write data.
- addr  in  ADDR_W  word address, full range 0..1023 valid.
- wr  in  1  1 = write, 0 = read; qualified by cs.
- cs  in  1  chip select, active-high; cs=0 means no access.
- busy  out  1  high while the clear sweep runs; accesses are ignored.
- parity_err  out  1  parity mismatch on the last read; see Configuration.

## Operation
- FSM states: CLEAR and READY.
- Reset (rst_n=0, asynchronous) forces the following values:
  - state=CLEAR, clear counter=0.
  - busy=1, data_out=0, parity_err=0.
  - Memory contents are not reset directly.
- CLEAR state:
  - Each cycle, write 0 (and correct parity) to mem[counter], then increment the counter.
  - After the cycle that writes address 1023, go to READY and set busy=0.
  - cs, wr, addr and data_in are ignored. data_out and parity_err hold 0.
- READY state, per rising edge:
  - cs=1, wr=1: write mem[addr] <= data_in. data_out holds its previous value; there is no write-through.
  - cs=1, wr=0: read, data_out <= mem[addr].
  - cs=0: no access; data_out and parity_err hold.
- Address wrap-around is impossible: all 10-bit values are legal, with no bounds check.
- Reset asserted mid-sweep or mid-operation aborts immediately and the sweep restarts from address 0.

## Timing
- Read latency is 1 cycle: data for a read sampled at edge N is valid on data_out after edge N.
- A read at edge N+1 of the address written at edge N returns the new data.
- Back-to-back accesses are allowed every cycle; there is no handshake.
- After rst_n deasserts, busy stays high for exactly 1024 rising edges. The first accepted access is at edge 1025.

## Configuration
- RAM3_PARITY_EN defined:
  - Each word stores DATA_W+1 bits; the extra bit is even parity of the data.
  - On each read, parity_err is registered with data_out and set to 1 if the recomputed parity differs from the stored bit.
  - Writes and the clear sweep store correct parity.
- RAM3_PARITY_EN undefined:
  - Storage is DATA_W bits.
  - parity_err is tied to 0; the port is still present.

## Structure
- Package ram3_pkg holds DATA_W, ADDR_W, DEPTH and the state enum (CLEAR, READY).
- One sub-module, ram3_mem: the storage array with a single synchronous write port and a synchronous read port.
- The top level contains the clear FSM and counter, access muxing and parity logic.

## Test plan
- Reset clear: pulse rst_n low, count edges with busy=1 -> exactly 1024. Then read 0, 511 and 1023 -> data_out=0 each.
- Fill and readback: write (2k)%256 to every address k=0..1023, then read all -> address 300 returns 88, address 1023 returns 254.
- Read latency and no write-through: write 8'hA5 to address 7. data_out is unchanged after the write edge. Read address 7 -> 8'hA5 on the next edge.
- Deselect hold: read address 5 (value 10), then run cycles with cs=0 and wr=1, data_in=8'hFF -> data_out stays 10 and mem[5] is unchanged.
- Reset mid-sweep: assert rst_n at sweep cycle 500 -> busy stays 1, then release -> 1024 further busy cycles, and all locations read 0.
- Parity (RAM3_PARITY_EN only): write 8'h3C, then force-flip a stored data bit via hierarchical access and read -> parity_err=1. Normal reads -> parity_err=0.
